// File: rtl/even_wb_merge.sv
`default_nettype none
// ============================================================================
// Module   : even_wb_merge
// Purpose  : Even-pipe writeback merge. Queues int/fp/fx results in program
//            order and retires one per cycle to the even register-file port.
//            Define EVEN_WB_FWD_EN to build the queued-value forwarding search.
// Revision : 1.0 - initial release
// ============================================================================
module even_wb_merge #(
  parameter int DEPTH        = 8,
  parameter int STALL_THRESH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         int_we,
  input  logic [6:0]   int_addr,
  input  logic [127:0] int_data,
  input  logic         fp_we,
  input  logic [6:0]   fp_addr,
  input  logic [127:0] fp_data,
  input  logic         fx_we,
  input  logic [6:0]   fx_addr,
  input  logic [127:0] fx_data,
  output logic         rf_we,
  output logic [6:0]   rf_addr,
  output logic [127:0] rf_data,
  output logic         wb_stall,
  output logic         wb_overflow,
  input  logic [6:0]   q_addr_a,
  input  logic [6:0]   q_addr_b,
  input  logic [6:0]   q_addr_c,
  output logic         fwd_hit_a,
  output logic         fwd_hit_b,
  output logic         fwd_hit_c,
  output logic [127:0] fwd_data_a,
  output logic [127:0] fwd_data_b,
  output logic [127:0] fwd_data_c
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [6:0]    addr_mem_q [DEPTH];
  logic [127:0]  data_mem_q [DEPTH];

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          rf_we_q, rf_we_d;
  logic [6:0]    rf_addr_q, rf_addr_d;
  logic [127:0]  rf_data_q, rf_data_d;
  logic          stall_q, stall_d;
  logic          overflow_q, overflow_d;

  logic [2:0]    src_we;
  logic [6:0]    src_addr [3];
  logic [127:0]  src_data [3];
  logic [2:0]    wr_en;
  logic [AW-1:0] wr_idx [3];
  logic          pop;
  logic [CW-1:0] pop_ext;
  logic [CW-1:0] free_slots;
  logic [CW-1:0] n_acc;
  logic          drop;

  always_comb begin
    src_we      = {fx_we, fp_we, int_we};
    src_addr[0] = int_addr;
    src_addr[1] = fp_addr;
    src_addr[2] = fx_addr;
    src_data[0] = int_data;
    src_data[1] = fp_data;
    src_data[2] = fx_data;

    pop        = (count_q != '0);
    pop_ext    = {{(CW-1){1'b0}}, pop};
    // Space freed by this cycle's pop is usable by this cycle's pushes.
    free_slots = CW'(DEPTH) - (count_q - pop_ext);

    n_acc = '0;
    drop  = 1'b0;
    for (int s = 0; s < 3; s++) begin
      wr_en[s]  = 1'b0;
      wr_idx[s] = tail_q + n_acc[AW-1:0];
      if (src_we[s]) begin
        if (n_acc < free_slots) begin
          wr_en[s] = 1'b1;
          n_acc    = n_acc + CW'(1);
        end else begin
          drop = 1'b1;
        end
      end
    end

    head_d     = head_q + AW'(pop);
    tail_d     = tail_q + n_acc[AW-1:0];
    count_d    = count_q - pop_ext + n_acc;
    rf_we_d    = pop;
    rf_addr_d  = pop ? addr_mem_q[head_q] : 7'd0;
    rf_data_d  = pop ? data_mem_q[head_q] : 128'd0;
    stall_d    = (count_d >= CW'(STALL_THRESH));
    overflow_d = overflow_q | drop;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      rf_we_q    <= 1'b0;
      rf_addr_q  <= 7'd0;
      rf_data_q  <= 128'd0;
      stall_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      rf_we_q    <= rf_we_d;
      rf_addr_q  <= rf_addr_d;
      rf_data_q  <= rf_data_d;
      stall_q    <= stall_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is left unreset; validity is tracked by head/count alone.
  always_ff @(posedge clk) begin
    for (int s = 0; s < 3; s++) begin
      if (wr_en[s]) begin
        addr_mem_q[wr_idx[s]] <= src_addr[s];
        data_mem_q[wr_idx[s]] <= src_data[s];
      end
    end
  end

  assign rf_we       = rf_we_q;
  assign rf_addr     = rf_addr_q;
  assign rf_data     = rf_data_q;
  assign wb_stall    = stall_q;
  assign wb_overflow = overflow_q;

`ifdef EVEN_WB_FWD_EN
  // Walk oldest to youngest so the last match wins.
  function automatic logic [128:0] fwd_lookup(input logic [6:0] qa);
    logic [128:0]  res;
    logic [AW-1:0] idx;
    res = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + AW'(i);
      if ((CW'(i) < count_q) && (addr_mem_q[idx] == qa)) begin
        res = {1'b1, data_mem_q[idx]};
      end
    end
    return res;
  endfunction

  logic [128:0] fwd_a, fwd_b, fwd_c;

  always_comb begin
    fwd_a = fwd_lookup(q_addr_a);
    fwd_b = fwd_lookup(q_addr_b);
    fwd_c = fwd_lookup(q_addr_c);
  end

  assign fwd_hit_a  = fwd_a[128];
  assign fwd_data_a = fwd_a[127:0];
  assign fwd_hit_b  = fwd_b[128];
  assign fwd_data_b = fwd_b[127:0];
  assign fwd_hit_c  = fwd_c[128];
  assign fwd_data_c = fwd_c[127:0];
`else
  logic unused_q_addr;
  assign unused_q_addr = ^{q_addr_a, q_addr_b, q_addr_c};

  assign fwd_hit_a  = 1'b0;
  assign fwd_hit_b  = 1'b0;
  assign fwd_hit_c  = 1'b0;
  assign fwd_data_a = 128'd0;
  assign fwd_data_b = 128'd0;
  assign fwd_data_c = 128'd0;
`endif

endmodule
`default_nettype wire
